// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Program-counter sequencer and run controller for the single-cycle 9-bit
// core. Owns the PC and picks between sequential fetch and a branch target
// taken from a 4-entry programmable table indexed by the decoder's how_high
// field. Holds the PC while data memory is busy. Also runs the start/done
// handshake with the test harness: a second 4-entry table holds the program
// entry points, and a saturating counter records RUN cycles per program run.
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (ignored while running)
//   prog_sel   in   entry-point index, sampled together with start
//   branch     in   taken-branch request from the decoder
//   how_high   in   branch-target table index
//   halt       in   current instruction ends the program
//   mem_busy   in   data memory not ready, hold the PC
//   cfg_we     in   table write strobe
//   cfg_sel    in   0: branch table, 1: start table
//   cfg_idx    in   table entry index
//   cfg_data   in   absolute address to write
//   pc         out  instruction ROM address
//   run        out  pc is a valid fetch, decoder inputs are meaningful
//   done       out  program finished, held until the next start
//   cycle_cnt  out  RUN cycles of the current / last run

module pc_sequencer #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             branch,
    input  logic [1:0]       how_high,
    input  logic             halt,
    input  logic             mem_busy,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [1:0]       cfg_idx,
    input  logic [PC_W-1:0]  cfg_data,
    output logic [PC_W-1:0]  pc,
    output logic             run,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   brTab_q    [4];
    logic [PC_W-1:0]   startTab_q [4];

    // State, PC, counter and done flag. Everything clears asynchronously so a
    // reset mid-run takes effect without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Target tables. The sequencing logic reads the _q values, so a write
    // and a read of the same entry on one edge sees the old contents; the
    // new value is used from the following edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                brTab_q[i]    <= '0;
                startTab_q[i] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_sel) begin
                startTab_q[cfg_idx] <= cfg_data;
            end else begin
                brTab_q[cfg_idx]    <= cfg_data;
            end
        end
    end

    // Next-state logic. In RUN, halt beats a stall, and a stall beats a
    // branch. The counter advances on every RUN cycle including stalls and
    // the halting cycle, and sticks at all-ones rather than wrapping.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        case (state_q)
            RUN: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (halt) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (mem_busy) begin
                    pc_d = pc_q;
                end else if (branch) begin
                    pc_d = brTab_q[how_high];
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                // IDLE and HALT both launch a run the same way.
                if (start) begin
                    state_d = RUN;
                    pc_d    = startTab_q[prog_sel];
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
        endcase
    end

    assign pc        = pc_q;
    assign run       = (state_q == RUN);
    assign done      = done_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//
// Drives pc_sequencer with directed scenarios followed by randomized
// stimulus, and compares every output after each edge against a behavioural
// model of the run controller kept in this module.

module tb_pc_sequencer;

    localparam int PC_W   = 10;
    localparam int CNT_W  = 16;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       prog_sel;
    logic             branch;
    logic [1:0]       how_high;
    logic             halt;
    logic             mem_busy;
    logic             cfg_we;
    logic             cfg_sel;
    logic [1:0]       cfg_idx;
    logic [PC_W-1:0]  cfg_data;
    logic [PC_W-1:0]  pc;
    logic             run;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers describing what the run controller
    // should be doing.
    bit mRunning;
    bit mDone;
    int mPc;
    int mCnt;
    int mBr [4];
    int mSt [4];

    pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_sel  (prog_sel),
        .branch    (branch),
        .how_high  (how_high),
        .halt      (halt),
        .mem_busy  (mem_busy),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .pc        (pc),
        .run       (run),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mRunning = 1'b0;
        mDone    = 1'b0;
        mPc      = 0;
        mCnt     = 0;
        for (int i = 0; i < 4; i++) begin
            mBr[i] = 0;
            mSt[i] = 0;
        end
    endtask

    // One clock edge of the model. Sequencing decisions are made before the
    // table write is applied, so same-edge reads see the old entry.
    task automatic modelStep(input bit st, input int ps, input bit br, input int hh,
                             input bit hl, input bit mb, input bit we, input bit cs,
                             input int ci, input int cd);
        if (mRunning) begin
            mCnt = (mCnt < CNT_MX) ? mCnt + 1 : CNT_MX;
            if (hl) begin
                mRunning = 1'b0;
                mDone    = 1'b1;
            end else if (!mb) begin
                mPc = br ? mBr[hh] : (mPc + 1) % PC_MOD;
            end
        end else if (st) begin
            mRunning = 1'b1;
            mDone    = 1'b0;
            mPc      = mSt[ps];
            mCnt     = 0;
        end
        if (we) begin
            if (cs) mSt[ci] = cd;
            else    mBr[ci] = cd;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pc"},   int'(pc),        mPc);
        checkOutput({tag, ".run"},  int'(run),       int'(mRunning));
        checkOutput({tag, ".done"}, int'(done),      int'(mDone));
        checkOutput({tag, ".cnt"},  int'(cycle_cnt), mCnt);
    endtask

    // Drive one cycle of inputs away from the active edge, advance the
    // model, then compare just after the edge.
    task automatic applyStimulus(input string tag,
                                 input bit st, input int ps, input bit br, input int hh,
                                 input bit hl, input bit mb,
                                 input bit we, input bit cs, input int ci, input int cd);
        @(negedge clk);
        start    = st;
        prog_sel = 2'(ps);
        branch   = br;
        how_high = 2'(hh);
        halt     = hl;
        mem_busy = mb;
        cfg_we   = we;
        cfg_sel  = cs;
        cfg_idx  = 2'(ci);
        cfg_data = PC_W'(cd);
        modelStep(st, ps, br, hh, hl, mb, we, cs, ci, cd);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfgWrite(input string tag, input bit cs, input int ci, input int cd);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 1, cs, ci, cd);
    endtask

    task automatic startRun(input string tag, input int ps);
        applyStimulus(tag, 1, ps, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic haltRun(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        prog_sel = '0;
        branch   = 1'b0;
        how_high = '0;
        halt     = 1'b0;
        mem_busy = 1'b0;
        cfg_we   = 1'b0;
        cfg_sel  = 1'b0;
        cfg_idx  = '0;
        cfg_data = '0;
        modelReset();

        #2;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] start from entry table");
        cfgWrite("cfgSt2", 1, 2, 'h040);
        startRun("start2", 2);
        checkOutput("start2.pcConst", int'(pc), 'h040);
        checkOutput("start2.cntConst", int'(cycle_cnt), 0);
        idleStep("seq1");
        checkOutput("seq1.pcConst", int'(pc), 'h041);
        idleStep("seq2");
        checkOutput("seq2.pcConst", int'(pc), 'h042);
        applyStimulus("startIgnored", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("startIgnored.pcConst", int'(pc), 'h043);

        $display("[TB] branch through target table");
        cfgWrite("cfgBr1", 0, 1, 'h123);
        cfgWrite("cfgSt3", 1, 3, 'h050);
        haltRun("halt1");
        startRun("start3", 3);
        applyStimulus("branch1", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("branch1.pcConst", int'(pc), 'h123);
        idleStep("afterBranch");
        checkOutput("afterBranch.pcConst", int'(pc), 'h124);

        $display("[TB] stall and priority");
        cfgWrite("cfgSt0", 1, 0, 'h010);
        haltRun("halt2");
        startRun("start0", 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        end
        checkOutput("stall.pcConst", int'(pc), 'h010);
        checkOutput("stall.cntConst", int'(cycle_cnt), 3);
        applyStimulus("haltWins", 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("haltWins.pcConst", int'(pc), 'h010);
        checkOutput("haltWins.doneConst", int'(done), 1);

        $display("[TB] wrap and same-edge table write");
        cfgWrite("cfgSt1", 1, 1, 'h3FE);
        cfgWrite("cfgBr0", 0, 0, 'h100);
        startRun("start1", 1);
        idleStep("wrap1");
        checkOutput("wrap1.pcConst", int'(pc), 'h3FF);
        idleStep("wrap2");
        checkOutput("wrap2.pcConst", int'(pc), 'h000);
        applyStimulus("brOld", 0, 0, 1, 0, 0, 0, 1, 0, 0, 'h200);
        checkOutput("brOld.pcConst", int'(pc), 'h100);
        applyStimulus("brNew", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("brNew.pcConst", int'(pc), 'h200);

        $display("[TB] halt count and restart");
        haltRun("halt3");
        startRun("start2b", 2);
        for (int i = 0; i < 4; i++) idleStep("count");
        haltRun("halt5");
        checkOutput("halt5.cntConst", int'(cycle_cnt), 5);
        applyStimulus("haltIgnoresInputs", 0, 0, 1, 2, 1, 1, 0, 0, 0, 0);
        checkOutput("doneHeld", int'(done), 1);
        startRun("restart", 2);
        checkOutput("restart.doneConst", int'(done), 0);

        $display("[TB] asynchronous reset mid-run");
        idleStep("preReset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("asyncReset");
        @(negedge clk);
        rst_n = 1'b1;
        startRun("startAfterReset", 2);
        checkOutput("tableCleared", int'(pc), 0);

        $display("[TB] randomized stimulus");
        for (int n = 0; n < 600; n++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3)),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          bit'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)),
                          int'($urandom_range(0, PC_MOD - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
